// File: rtl/aes_pkg.sv
// aes_pkg: block type, FSM states, Rcon and GF(2^8) helpers
// shared by the AES-128 inverse cipher and its round logic.
package aes_pkg;

  typedef logic [0:15][7:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] blk_byte(
    input block_t     b,
    input logic [3:0] i
  );
    return b[i];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0.
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] p;
    logic [7:0] sq;
    p  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = gf_inv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] s
  );
    logic [7:0] b;
    b = {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_128_decryptor_inv_round.sv
// aes_inv_round: InvShiftRows, InvSubBytes, AddRoundKey and
// InvMixColumns; 'last' bypasses InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] din,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] dout
);

  localparam logic [7:0] MC [0:3] = '{
    8'h0e, 8'h0b, 8'h0d, 8'h09
  };

  block_t s;
  block_t k;
  block_t sr;
  block_t ak;
  block_t mc;

  // Row r rotates right by r byte positions.
  always_comb begin
    s  = din;
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = blk_byte(s, 4'(4*((c+4-r)%4)+r));
      end
    end
  end

  // Inverse S-box on each byte, then add the round key.
  always_comb begin
    k  = rk;
    ak = '0;
    for (int i = 0; i < 16; i++) begin
      ak[i] = inv_sbox(sr[i]) ^ k[i];
    end
  end

  // Column mix with the circulant {0e,0b,0d,09}.
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          mc[4*c+r] = mc[4*c+r]
            ^ gf_mul(ak[4*c+j], MC[(j+4-r)%4]);
        end
      end
    end
  end

  // Final round skips the column mix.
  always_comb begin
    dout = last ? ak : mc;
  end

endmodule

// File: rtl/aes_128_decryptor.sv
// aes_128_decryptor: iterative AES-128 inverse cipher, one round/clk.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion on a repeated key.
module aes_128_decryptor
  import aes_pkg::*;
#(
  parameter int NR = 10
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state
);

  if (NR != 10) begin : g_nr_check
    $error("aes_128_decryptor: NR must be 10");
  end

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [127:0] work_q;
  logic [127:0] st_q;
  logic         ov_q;
  logic         live_q;
  logic [3:0]   cnt_q;
  logic [127:0] rk [0:10];

  logic [127:0] rk_cur;
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [31:0]  kw3;
  logic [31:0]  ktmp;
  logic [127:0] round_out;
  logic         accept;
  logic         hit;

  assign in_ready  = live_q && (fsm_q == IDLE);
  assign out_valid = ov_q;
  assign state     = st_q;
  assign accept    = in_valid && in_ready;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_q;

  // Cached schedule is valid once a full expansion has finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= 1'b0;
    end else if (accept && !hit) begin
      cache_q <= 1'b0;
    end else if (fsm_q == KEYEXP && cnt_q == 4'd10) begin
      cache_q <= 1'b1;
    end
  end

  assign hit = cache_q && (key == rk[0]);
`else
  assign hit = 1'b0;
`endif

  assign rk_cur  = rk[cnt_q];
  assign rk_prev = rk[cnt_q - 4'd1];

  // One forward key-expansion step: rk[i] from rk[i-1].
  always_comb begin
    kw3  = rk_prev[31:0];
    ktmp = {sbox(kw3[23:16]), sbox(kw3[15:8]),
            sbox(kw3[7:0]),   sbox(kw3[31:24])}
         ^ {RCON[cnt_q], 24'h0};
    rk_next[127:96] = rk_prev[127:96] ^ ktmp;
    rk_next[95:64]  = rk_prev[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_prev[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_prev[31:0]   ^ rk_next[63:32];
  end

  aes_inv_round u_round (
    .din  (work_q),
    .rk   (rk_cur),
    .last (fsm_q == FINAL),
    .dout (round_out)
  );

  // Next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (accept) fsm_d = hit ? INIT : KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10) fsm_d = INIT;
      INIT:    fsm_d = ROUND;
      ROUND:   if (cnt_q == 4'd1) fsm_d = FINAL;
      FINAL:   fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State register, round counter and data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      work_q <= '0;
      st_q   <= '0;
      ov_q   <= 1'b0;
      live_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      fsm_q  <= fsm_d;
      live_q <= 1'b1;
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            work_q <= cipher;
            cnt_q  <= hit ? 4'd10 : 4'd1;
          end
        end
        KEYEXP: begin
          if (cnt_q != 4'd10) cnt_q <= cnt_q + 4'd1;
        end
        INIT: begin
          work_q <= work_q ^ rk_cur;
          cnt_q  <= 4'd9;
        end
        ROUND: begin
          work_q <= round_out;
          cnt_q  <= cnt_q - 4'd1;
        end
        FINAL: begin
          st_q <= round_out;
          ov_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) ov_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Round-key file: key into slot 0, expansion fills 1..10.
  always_ff @(posedge clk) begin
    if (accept) begin
      rk[0] <= key;
    end else if (fsm_q == KEYEXP) begin
      rk[cnt_q] <= rk_next;
    end
  end

endmodule

// File: tb/tb_aes_128_decryptor.sv
// tb_aes_128_decryptor: FIPS-197 vectors, backpressure, reset,
// busy-input and random blocks against a textbook InvCipher model.
module tb_aes_128_decryptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] cipher = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] state;

  aes_128_decryptor #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher    (cipher),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state     (state)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  task automatic fail_now(input string n);
    nvec++;
    nerr++;
    $display("FAIL %s: event did not occur within its bound", n);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] k,
                                             input logic [127:0] c);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int col = 0; col < 4; col++)
      for (int r = 0; r < 4; r++)
        s[r][col] = c[127-8*(4*col+r) -: 8] ^ w[40+col][31-8*r -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          t[r][col] = isb[s[r][(col+4-r)%4]];
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          s[r][col] = t[r][col] ^ w[4*rnd+col][31-8*r -: 8];
      if (rnd > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[0][col]; a1 = s[1][col]; a2 = s[2][col]; a3 = s[3][col];
          s[0][col] = gm(a0,8'h0e)^gm(a1,8'h0b)^gm(a2,8'h0d)^gm(a3,8'h09);
          s[1][col] = gm(a0,8'h09)^gm(a1,8'h0e)^gm(a2,8'h0b)^gm(a3,8'h0d);
          s[2][col] = gm(a0,8'h0d)^gm(a1,8'h09)^gm(a2,8'h0e)^gm(a3,8'h0b);
          s[3][col] = gm(a0,8'h0b)^gm(a1,8'h0d)^gm(a2,8'h09)^gm(a3,8'h0e);
        end
      end
    end
    res = '0;
    for (int col = 0; col < 4; col++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*col+r) -: 8] = s[r][col];
    return res;
  endfunction

  // Key cache as seen from outside: last accepted key, cleared by reset.
  logic         cvld = 1'b0;
  logic [127:0] ckey = '0;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic prev_ov = 1'b0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_state", state, 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      prev_ov = 1'b0;
    end else if (out_valid) begin
      if (!prev_ov) begin
        if (q.size() == 0) begin
          fail_now("spurious_out_valid");
          cur.exp = 'x;
        end else begin
          cur = q.pop_front();
          chk("latency", 128'(cyc - cur.acc), 128'(cur.lat));
        end
      end
      chk("state", state, cur.exp);
      chk("busy_in_ready", 128'(in_ready), 128'(0));
      prev_ov = 1'b1;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] k, input logic [127:0] c,
                      output int acc, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    key = k;
    cipher = c;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      acc = -1;
      lat = 0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    lat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
    if (cvld && k == ckey) lat = 11;
    cvld = 1'b1;
    ckey = k;
`endif
    q.push_back('{model_dec(k, c), acc, lat});
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    repeat (300) begin
      if (q.size() == 0 && !out_valid) break;
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    if (q.size() != 0 || out_valid) fail_now("done_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cvld = 1'b0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, l1, a2, l2, n;
    logic [127:0] rk_prev;
    logic [127:0] k;
    build_tables();
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_isbox_16", 128'(isb[8'h16]), 128'hff);
    chk("model_c1", model_dec(K_C1, C_C1), P_C1);
    chk("model_b", model_dec(K_B, C_B), P_B);

    do_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", 128'(in_ready), 128'(1));

    // FIPS-197 C.1 and B.
    send(K_C1, C_C1, a1, l1);
    wait_idle(0);
    send(K_B, C_B, a1, l1);
    wait_idle(0);

    // Backpressure: hold the result for 10 cycles.
    out_ready = 1'b0;
    send(K_C1, C_C1, a1, l1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("bp_out_valid_timeout");
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid_held", 128'(out_valid), 128'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_out_valid_drop", 128'(out_valid), 128'(0));
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));

    // Reset at E0+14 discards the in-flight block.
    send(K_B, C_C1, a1, l1);
    repeat (13) @(posedge clk);
    #1 do_reset();
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_state", state, 128'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(K_C1, C_C1, a1, l1);
    wait_idle(0);

    // Inputs change while busy; second block waits for IDLE.
    send(K_C1, C_C1, a1, l1);
    in_valid = 1'b1;
    key = '0;
    cipher = '0;
    send(128'(0), 128'(0), a2, l2);
    chk("ii_after_busy", 128'(a2 - a1), 128'(l1 + 2));
    wait_idle(0);

    // Back-to-back same key, then a different key.
    send(K_C1, C_C1, a1, l1);
    send(K_C1, C_C1, a2, l2);
    chk("ii_same_key", 128'(a2 - a1), 128'(l1 + 2));
    send(K_B, C_B, a1, l1);
    chk("ii_new_key", 128'(a1 - a2), 128'(l2 + 2));
    wait_idle(0);

    // Random blocks, some reusing the previous key.
    rk_prev = K_B;
    for (int i = 0; i < 24; i++) begin
      k = (i % 4 == 1) ? rk_prev
        : {$urandom, $urandom, $urandom, $urandom};
      rk_prev = k;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(k, {$urandom, $urandom, $urandom, $urandom}, a1, l1);
      wait_idle(1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
